rect_draw_engine: RTL and testbench

// Parametrised rectangle rasteriser. Successor to the single fixed-square draw block.

---
 rtl/rect_draw_engine.sv | 195 +++++++++++++++++++
 tb/tb_rect_draw_engine.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rect_draw_engine.sv
// Rectangle rasteriser: clips one command to the screen, then streams its pixels in raster order
// (solid fill or BORDER-pixel outline) to the LT24 pixel-write interface.
module rect_draw_engine #(
  parameter int X_WIDTH  = 8,
  parameter int Y_WIDTH  = 9,
  parameter int SCREEN_W = 240,
  parameter int SCREEN_H = 320,
  parameter int BORDER   = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cmdValid,
  output logic                       cmdReady,
  input  logic [X_WIDTH-1:0]         cmdX,
  input  logic [Y_WIDTH-1:0]         cmdY,
  input  logic [X_WIDTH-1:0]         cmdWidth,
  input  logic [Y_WIDTH-1:0]         cmdHeight,
  input  logic [15:0]                cmdColour,
  input  logic                       cmdMode,
  output logic                       pixelWrite,
  input  logic                       pixelReady,
  output logic [X_WIDTH-1:0]         xAddr,
  output logic [Y_WIDTH-1:0]         yAddr,
  output logic [15:0]                pixelData,
  output logic                       busy,
  output logic                       done,
  output logic [X_WIDTH+Y_WIDTH-1:0] pixelCount
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CLIP = 2'd1;
  localparam logic [1:0] S_DRAW = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int XP = X_WIDTH + 1;
  localparam int YP = Y_WIDTH + 1;
  localparam int CW = X_WIDTH + Y_WIDTH;

  localparam logic [XP-1:0]      X_MAX   = XP'(SCREEN_W - 1);
  localparam logic [YP-1:0]      Y_MAX   = YP'(SCREEN_H - 1);
  localparam logic [XP-1:0]      X_BORD  = XP'(BORDER);
  localparam logic [YP-1:0]      Y_BORD  = YP'(BORDER);
  localparam logic [X_WIDTH-1:0] X_BACK  = X_WIDTH'(BORDER - 1);

  logic [1:0]         state_q, state_d;
  logic [X_WIDTH-1:0] cmd_x_q, cmd_x_d, cmd_w_q, cmd_w_d;
  logic [Y_WIDTH-1:0] cmd_y_q, cmd_y_d, cmd_h_q, cmd_h_d;
  logic [15:0]        colour_q, colour_d;
  logic               mode_q, mode_d;
  logic [X_WIDTH-1:0] x_end_q, x_end_d, x_q, x_d;
  logic [Y_WIDTH-1:0] y_end_q, y_end_d, y_q, y_d;
  logic [15:0]        data_q, data_d;
  logic               write_q, write_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CW-1:0]      pixel_count_q, pixel_count_d;

  // Clip arithmetic is one bit wider than the coordinates so origin+size cannot wrap.
  logic [XP-1:0]      x_last_full;
  logic [YP-1:0]      y_last_full;
  logic               degenerate;
  logic [X_WIDTH-1:0] x_end_clip;
  logic [Y_WIDTH-1:0] y_end_clip;

  assign x_last_full = {1'b0, cmd_x_q} + {1'b0, cmd_w_q} - XP'(1);
  assign y_last_full = {1'b0, cmd_y_q} + {1'b0, cmd_h_q} - YP'(1);
  assign degenerate  = (cmd_w_q == '0) || (cmd_h_q == '0) ||
                       ({1'b0, cmd_x_q} > X_MAX) || ({1'b0, cmd_y_q} > Y_MAX);
  assign x_end_clip  = (x_last_full > X_MAX) ? X_MAX[X_WIDTH-1:0] : x_last_full[X_WIDTH-1:0];
  assign y_end_clip  = (y_last_full > Y_MAX) ? Y_MAX[Y_WIDTH-1:0] : y_last_full[Y_WIDTH-1:0];

  logic               row_end, last_pixel, interior_row, skip_interior;
  logic [X_WIDTH-1:0] x_inc, x_jump;

  assign row_end      = (x_q == x_end_q);
  assign last_pixel   = row_end && (y_q == y_end_q);
  assign interior_row = ({1'b0, y_q} >= {1'b0, cmd_y_q} + Y_BORD) &&
                        ({1'b0, y_q} + Y_BORD <= {1'b0, y_end_q});
  assign x_inc        = x_q + 1'b1;
  assign x_jump       = x_end_q - X_BACK;
  // In outline mode an interior row leaves the left border straight onto the right border.
  assign skip_interior = mode_q && interior_row &&
                         ({1'b0, x_q} + XP'(1) >= {1'b0, cmd_x_q} + X_BORD) &&
                         ({1'b0, x_q} + X_BORD < {1'b0, x_end_q});

  always_comb begin
    // NOTE: every _d gets its _q as a default first, so no path through the case can infer a latch.
    state_d       = state_q;
    cmd_x_d       = cmd_x_q;
    cmd_y_d       = cmd_y_q;
    cmd_w_d       = cmd_w_q;
    cmd_h_d       = cmd_h_q;
    colour_d      = colour_q;
    mode_d        = mode_q;
    x_end_d       = x_end_q;
    y_end_d       = y_end_q;
    x_d           = x_q;
    y_d           = y_q;
    data_d        = data_q;
    write_d       = write_q;
    count_d       = count_q;
    pixel_count_d = pixel_count_q;
    case (state_q)
      S_IDLE: begin
        if (cmdValid) begin
          cmd_x_d  = cmdX;
          cmd_y_d  = cmdY;
          cmd_w_d  = cmdWidth;
          cmd_h_d  = cmdHeight;
          colour_d = cmdColour;
          mode_d   = cmdMode;
          state_d  = S_CLIP;
        end
      end
      S_CLIP: begin
        if (degenerate) begin
          pixel_count_d = '0;
          state_d       = S_DONE;
        end else begin
          x_end_d = x_end_clip;
          y_end_d = y_end_clip;
          x_d     = cmd_x_q;
          y_d     = cmd_y_q;
          data_d  = colour_q;
          write_d = 1'b1;
          count_d = '0;
          state_d = S_DRAW;
        end
      end
      S_DRAW: begin
        if (write_q && pixelReady) begin
          count_d = count_q + 1'b1;
          if (last_pixel) begin
            write_d       = 1'b0;
            pixel_count_d = count_q + 1'b1;
            state_d       = S_DONE;
          end else if (row_end) begin
            x_d = cmd_x_q;
            y_d = y_q + 1'b1;
          end else begin
            x_d = skip_interior ? x_jump : x_inc;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cmd_x_q       <= '0;
      cmd_y_q       <= '0;
      cmd_w_q       <= '0;
      cmd_h_q       <= '0;
      colour_q      <= '0;
      mode_q        <= 1'b0;
      x_end_q       <= '0;
      y_end_q       <= '0;
      x_q           <= '0;
      y_q           <= '0;
      data_q        <= '0;
      write_q       <= 1'b0;
      count_q       <= '0;
      pixel_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cmd_x_q       <= cmd_x_d;
      cmd_y_q       <= cmd_y_d;
      cmd_w_q       <= cmd_w_d;
      cmd_h_q       <= cmd_h_d;
      colour_q      <= colour_d;
      mode_q        <= mode_d;
      x_end_q       <= x_end_d;
      y_end_q       <= y_end_d;
      x_q           <= x_d;
      y_q           <= y_d;
      data_q        <= data_d;
      write_q       <= write_d;
      count_q       <= count_d;
      pixel_count_q <= pixel_count_d;
    end
  end

  assign cmdReady   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign pixelWrite = write_q;
  assign xAddr      = x_q;
  assign yAddr      = y_q;
  assign pixelData  = data_q;
  assign pixelCount = pixel_count_q;

endmodule

// File: tb/tb_rect_draw_engine.sv
// Directed bench for rect_draw_engine: fill, outline, clipping, degenerate commands,
// random back-pressure with ignored commands, and asynchronous reset mid-draw.
module tb_rect_draw_engine;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cmdValid = 1'b0;
  logic        cmdReady;
  logic [7:0]  cmdX = '0;
  logic [8:0]  cmdY = '0;
  logic [7:0]  cmdWidth = '0;
  logic [8:0]  cmdHeight = '0;
  logic [15:0] cmdColour = '0;
  logic        cmdMode = 1'b0;
  logic        pixelWrite;
  logic        pixelReady = 1'b1;
  logic [7:0]  xAddr;
  logic [8:0]  yAddr;
  logic [15:0] pixelData;
  logic        busy;
  logic        done;
  logic [16:0] pixelCount;

  rect_draw_engine dut (
    .clock      (clock),
    .reset      (reset),
    .cmdValid   (cmdValid),
    .cmdReady   (cmdReady),
    .cmdX       (cmdX),
    .cmdY       (cmdY),
    .cmdWidth   (cmdWidth),
    .cmdHeight  (cmdHeight),
    .cmdColour  (cmdColour),
    .cmdMode    (cmdMode),
    .pixelWrite (pixelWrite),
    .pixelReady (pixelReady),
    .xAddr      (xAddr),
    .yAddr      (yAddr),
    .pixelData  (pixelData),
    .busy       (busy),
    .done       (done),
    .pixelCount (pixelCount)
  );

  always #5 clock = ~clock;

  typedef struct {
    int x;
    int y;
  } pix_t;

  pix_t exp_q[$];
  int   total = 0;
  int   passed = 0;
  int   fails = 0;
  int   last_count = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Hand model for a one-pixel border: every in-screen pixel of the clipped box on its edge.
  task automatic build_expected(input int x, input int y, input int w, input int h,
                                input bit mode, output int p);
    int xe, ye;
    exp_q.delete();
    p = 0;
    if (w == 0 || h == 0 || x >= 240 || y >= 320) return;
    xe = (x + w - 1 > 239) ? 239 : x + w - 1;
    ye = (y + h - 1 > 319) ? 319 : y + h - 1;
    for (int yy = y; yy <= ye; yy++)
      for (int xx = x; xx <= xe; xx++)
        if (!mode || xx == x || xx == xe || yy == y || yy == ye) begin
          exp_q.push_back('{x: xx, y: yy});
          p++;
        end
  endtask

  task automatic run_cmd(input int x, input int y, input int w, input int h,
                         input logic [15:0] col, input bit mode, input bit rnd,
                         input bit spam, input int abort_after);
    int   p, cyc, n, first_cyc;
    bit   stalled;
    pix_t e;
    logic [7:0]  sx;
    logic [8:0]  sy;
    logic [15:0] sd;
    build_expected(x, y, w, h, mode, p);
    cmdX      = 8'(x);
    cmdY      = 9'(y);
    cmdWidth  = 8'(w);
    cmdHeight = 9'(h);
    cmdColour = col;
    cmdMode   = mode;
    cmdValid  = 1'b1;
    pixelReady = 1'b1;
    chk("accept_ready", 32'(cmdReady), 1);
    tick();
    cyc = 1;
    if (spam) begin
      cmdX = 8'd0; cmdY = 9'd0; cmdWidth = 8'd1; cmdHeight = 9'd1;
      cmdColour = 16'h07E0; cmdMode = 1'b0;
    end else begin
      cmdValid = 1'b0;
    end
    chk("clip_busy", 32'(busy), 1);
    chk("clip_no_write", 32'(pixelWrite), 0);
    chk("clip_not_ready", 32'(cmdReady), 0);
    chk("count_held", 32'(pixelCount), last_count);
    n = 0;
    first_cyc = -1;
    stalled = 1'b0;
    sx = '0; sy = '0; sd = '0;
    while (done !== 1'b1 && cyc < 2000) begin
      pixelReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pixelWrite === 1'b1) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (stalled) begin
          chk("stall_x", 32'(xAddr), 32'(sx));
          chk("stall_y", 32'(yAddr), 32'(sy));
          chk("stall_data", 32'(pixelData), 32'(sd));
        end
        if (pixelReady) begin
          n++;
          if (exp_q.size() == 0) begin
            chk("extra_write", n, p);
          end else begin
            e = exp_q.pop_front();
            chk("px_x", 32'(xAddr), e.x);
            chk("px_y", 32'(yAddr), e.y);
            chk("px_data", 32'(pixelData), 32'(col));
          end
          if (n == abort_after) begin
            tick();
            return;
          end
        end
        stalled = !pixelReady;
        sx = xAddr; sy = yAddr; sd = pixelData;
      end else begin
        stalled = 1'b0;
      end
      tick();
      cyc++;
    end
    cmdValid = 1'b0;
    pixelReady = 1'b1;
    chk("done_seen", 32'(done), 1);
    chk("done_no_write", 32'(pixelWrite), 0);
    chk("pixel_count", 32'(pixelCount), p);
    chk("writes", n, p);
    chk("missing", exp_q.size(), 0);
    if (!rnd) chk("latency", cyc, p + 2);
    if (p > 0) chk("first_write", first_cyc, 2);
    last_count = p;
    tick();
    chk("done_pulse_end", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_ready", 32'(cmdReady), 1);
  endtask

  initial begin
    #2;
    chk("rst_write", 32'(pixelWrite), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_count", 32'(pixelCount), 0);
    chk("rst_ready", 32'(cmdReady), 1);
    chk("rst_xaddr", 32'(xAddr), 0);
    @(negedge clock);
    reset = 1'b1;
    tick();

    run_cmd(10, 20, 4, 3, 16'hF800, 1'b0, 1'b0, 1'b0, 0);   // fill 12
    run_cmd(0, 0, 5, 4, 16'h001F, 1'b1, 1'b0, 1'b0, 0);     // outline 14
    run_cmd(230, 315, 20, 10, 16'h07E0, 1'b0, 1'b0, 1'b0, 0); // clipped 50
    run_cmd(10, 10, 0, 5, 16'hFFFF, 1'b0, 1'b0, 1'b0, 0);   // zero width
    run_cmd(240, 10, 4, 4, 16'hFFFF, 1'b0, 1'b0, 1'b0, 0);  // off-screen x
    run_cmd(235, 10, 20, 4, 16'h1234, 1'b1, 1'b0, 1'b0, 0); // clipped outline 14
    run_cmd(236, 318, 10, 10, 16'h4321, 1'b1, 1'b0, 1'b0, 0); // 2-row outline = fill 8
    run_cmd(10, 20, 4, 3, 16'hF800, 1'b0, 1'b1, 1'b1, 0);   // back-pressure + ignored cmds

    // Reset asserted mid-draw, right after the fifth handshake.
    run_cmd(10, 20, 4, 3, 16'hF800, 1'b0, 1'b0, 1'b0, 5);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_write", 32'(pixelWrite), 0);
    chk("arst_xaddr", 32'(xAddr), 0);
    chk("arst_yaddr", 32'(yAddr), 0);
    chk("arst_data", 32'(pixelData), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_count", 32'(pixelCount), 0);
    chk("arst_ready", 32'(cmdReady), 1);
    tick();
    chk("arst_hold_write", 32'(pixelWrite), 0);
    @(negedge clock);
    reset = 1'b1;
    last_count = 0;
    tick();
    chk("post_rst_ready", 32'(cmdReady), 1);
    run_cmd(10, 20, 4, 3, 16'hF800, 1'b0, 1'b0, 1'b0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
